serial_compare16: RTL and testbench
===================================

// Module: serial_compare16
// PURPOSE
//  Bit-serial magnitude comparator: receives two unsigned WIDTH-bit operands one bit pair per
//  accepted cycle and reports a>b, b>a or a==b once the last bit arrives.
//  Serial-link counterpart of the lab's parallel 16-bit comparator.
//  Sits behind a serial operand source; result flags stay registered for a downstream consumer.
// PARAMETERS
//  WIDTH      16  operand width in bits (>=2); bit counter is $clog2(WIDTH+1) bits wide
//  MSB_FIRST  1   1: bits arrive MSB first; 0: LSB first
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  start      in   1  begin a new comparison; 1-cycle pulse
//  bit_valid  in   1  a_bit/b_bit hold a valid bit pair this cycle
//  a_bit      in   1  serial bit of operand a
//  b_bit      in   1  serial bit of operand b
//  busy       out  1  comparison in progress (SHIFT state)
//  done       out  1  1-cycle pulse: flags just updated
//  agreat     out  1  a > b   (registered, held until next done)
//  bgreat     out  1  b > a   (registered, held until next done)
//  equal      out  1  a == b  (registered, held until next done)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, count=0, busy=0, done=0, agreat=bgreat=equal=0.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : start -> SHIFT, count<=0, internal decision<=EQ. bit_valid ignored.
//   SHIFT: each cycle with bit_valid: sample pair, count++.
//          Sample of count==WIDTH-1 -> DONE. bit_valid=0 stalls; no timeout.
//          start in SHIFT aborts: count<=0, decision<=EQ, stay in SHIFT.
//          The bit_valid pair in that cycle is discarded; flags untouched.
//   DONE : done=1 for exactly this cycle; flags loaded from decision; next state IDLE.
//          start in DONE is accepted: next state SHIFT, new run begins.
//  Decision rule:
//   MSB_FIRST=1: the first differing pair decides; later pairs are ignored, but still counted.
//   MSB_FIRST=0: each differing pair overwrites the decision, so the last difference wins.
//   a_bit=1,b_bit=0 -> GT; a_bit=0,b_bit=1 -> LT; equal pairs leave the decision unchanged.
//  Flags: after the first done exactly one of agreat/bgreat/equal is 1. All three are 0 before it.
//  Flags change only in the DONE cycle; an aborted run never alters them.
//  busy=1 in SHIFT only; done and busy are never high together.
//  Latency: done asserts 1 cycle after the clock edge sampling the WIDTH-th valid pair.
//   Back-to-back minimum: start, WIDTH valid cycles, DONE = WIDTH+2 cycles per compare.
//  Reset mid-run: immediate return to the reset values above; the partial run is lost.
// STRUCTURE
//  Package cmp_pkg:
//   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} cmp_state_t
//   typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_result_t
//  Single module: FSM, bit counter and decision register.
//  No sub-module is warranted; counter and FSM are each under 30 lines.
// TESTING
//  1 Reset: rst_n=0 mid-SHIFT at bit 7 -> busy=done=flags=0 at once; a later clean run still works.
//  2 MSB_FIRST=1, a=16'h8000, b=16'h7FFF, bit_valid every cycle -> done at cycle 17 after start.
//    Result: agreat=1, bgreat=0, equal=0.
//  3 a=b=16'hA5A5 with bit_valid low every other cycle -> done after 16 valid pairs.
//    Result: equal=1; busy stays high for the 31 stalled/valid cycles.
//  4 MSB_FIRST=0, a=16'h0001, b=16'h0100 -> bgreat=1 (last difference wins).
//  5 Abort: start again after 5 pairs, then a=16'h0003, b=16'h0003 -> one done only; equal=1.
//    Previous flags are held through the abort.
//  6 start asserted in the DONE cycle of a run with a=16'hFFFF, b=0 -> first done gives agreat=1.
//    Second run with a=0, b=1 gives bgreat=1 after 16 more pairs; 1000 random pairs checked vs a>b/a<b/a==b.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and the per-bit decision step for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} cmp_state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_result_t;

  // keep_first=1 freezes the first difference (MSB-first order); otherwise the latest difference wins.
  function automatic cmp_result_t cmp_step(cmp_result_t cur, logic a, logic b, logic keep_first);
    if (a == b) return cur;
    if (keep_first && (cur != CMP_EQ)) return cur;
    return a ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/serial_compare16.sv
// Bit-serial unsigned comparator; flags load and done pulses 1 cycle after the WIDTH-th valid pair.
// bit_valid low simply stalls the shift (no timeout); start while busy restarts the run.
module serial_compare16
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic agreat,
  output logic bgreat,
  output logic equal
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cmp_state_t  state;
  cmp_result_t decision;
  cmp_result_t dec_next;
  logic [CW-1:0] count;

  assign dec_next = cmp_step(decision, a_bit, b_bit, MSB_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      decision <= CMP_EQ;
      busy     <= 1'b0;
      done     <= 1'b0;
      agreat   <= 1'b0;
      bgreat   <= 1'b0;
      equal    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_SHIFT;
            busy     <= 1'b1;
            count    <= '0;
            decision <= CMP_EQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (start) begin
            // Abort: the pair presented alongside start belongs to no run.
            count    <= '0;
            decision <= CMP_EQ;
          end else if (bit_valid) begin
            count    <= count + CW'(1);
            decision <= dec_next;
            if (count == LAST) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              agreat <= (dec_next == CMP_GT);
              bgreat <= (dec_next == CMP_LT);
              equal  <= (dec_next == CMP_EQ);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare16.sv
// Scoreboarded bench: one MSB-first and one LSB-first instance, directed steps plus random operands.
module tb_serial_compare16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [2];
  logic bv [2];
  logic ab [2];
  logic bb [2];
  logic busy [2];
  logic done [2];
  logic ag [2];
  logic bg [2];
  logic eq [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int dn [2];
  logic [2:0] q0 [$];
  logic [2:0] q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_compare16 #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bit_valid(bv[0]), .a_bit(ab[0]), .b_bit(bb[0]),
    .busy(busy[0]), .done(done[0]), .agreat(ag[0]), .bgreat(bg[0]), .equal(eq[0]));

  serial_compare16 #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bit_valid(bv[1]), .a_bit(ab[1]), .b_bit(bb[1]),
    .busy(busy[1]), .done(done[1]), .agreat(ag[1]), .bgreat(bg[1]), .equal(eq[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic push(input int sel, input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) q0.push_back(model(a, b));
    else q1.push_back(model(a, b));
  endtask

  // Scoreboard: every done pops one expected flag triple.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (done[s]) begin
          dn[s]++;
          chk($sformatf("queue_nonempty%0d", s), (s == 0) ? q0.size() : q1.size(), 32'd1 <= ((s == 0) ? q0.size() : q1.size()) ? ((s == 0) ? q0.size() : q1.size()) : 32'd1);
          if (s == 0 && q0.size() > 0) chk("flags0", {ag[0], bg[0], eq[0]}, q0.pop_front());
          if (s == 1 && q1.size() > 0) chk("flags1", {ag[1], bg[1], eq[1]}, q1.pop_front());
          chk($sformatf("done_busy_excl%0d", s), busy[s], 1'b0);
        end
      end
    end
  end

  task automatic start_pulse(input int sel, output int c0);
    c0 = cyc;
    st[sel] = 1'b1;
    bv[sel] = 1'b0;
    @(negedge clk);
    st[sel] = 1'b0;
  endtask

  task automatic feed(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input int n, input int gap, output int bc);
    int idx;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < ((i > 0) ? gap : 0); g++) begin
        bv[sel] = 1'b0;
        ab[sel] = ~a[0];
        if (busy[sel]) bc++;
        @(negedge clk);
      end
      idx = (sel == 0) ? 15 - i : i;
      bv[sel] = 1'b1;
      ab[sel] = a[idx];
      bb[sel] = b[idx];
      if (busy[sel]) bc++;
      @(negedge clk);
    end
    bv[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string tag);
    int w;
    w = 0;
    while (!done[sel] && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk(tag, done[sel], 1'b1);
  endtask

  initial begin
    int c0, bc, snap;
    logic [15:0] ra, rb;
    for (int s = 0; s < 2; s++) begin
      st[s] = 0; bv[s] = 0; ab[s] = 0; bb[s] = 0; dn[s] = 0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++)
      chk($sformatf("reset_outs%0d", s), {busy[s], done[s], ag[s], bg[s], eq[s]}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a run, after 7 pairs.
    start_pulse(0, c0);
    feed(0, 16'hFFFF, 16'h0000, 7, 0, bc);
    chk("busy_before_rst", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {busy[0], done[0], ag[0], bg[0], eq[0]}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back MSB-first run: latency 17 from the start cycle.
    push(0, 16'h8000, 16'h7FFF);
    start_pulse(0, c0);
    feed(0, 16'h8000, 16'h7FFF, 16, 0, bc);
    wait_done(0, "done_8000");
    chk("latency_17", cyc - c0, 17);
    chk("busy_16", bc, 16);
    @(negedge clk);
    chk("done_one_cycle", done[0], 1'b0);

    // Abort after 5 pairs that would have decided LT; old agreat must persist.
    start_pulse(0, c0);
    feed(0, 16'h0000, 16'hFFFF, 5, 0, bc);
    chk("held_through_partial", {ag[0], bg[0], eq[0]}, 3'b100);
    snap = dn[0];
    push(0, 16'h0003, 16'h0003);
    start_pulse(0, c0);
    chk("held_after_abort", {ag[0], bg[0], eq[0]}, 3'b100);
    chk("busy_after_abort", busy[0], 1'b1);
    feed(0, 16'h0003, 16'h0003, 16, 0, bc);
    wait_done(0, "done_abort");
    chk("abort_latency", cyc - c0, 17);
    @(negedge clk);
    chk("abort_single_done", dn[0] - snap, 1);

    // Equal operands with a stall between every pair.
    push(0, 16'hA5A5, 16'hA5A5);
    start_pulse(0, c0);
    feed(0, 16'hA5A5, 16'hA5A5, 16, 1, bc);
    chk("stall_busy_31", bc, 31);
    wait_done(0, "done_a5a5");
    chk("stall_latency_32", cyc - c0, 32);

    // LSB-first: the last (most significant) difference decides.
    push(1, 16'h0001, 16'h0100);
    start_pulse(1, c0);
    feed(1, 16'h0001, 16'h0100, 16, 0, bc);
    wait_done(1, "done_lsb");
    chk("lsb_bgreat", {ag[1], bg[1], eq[1]}, 3'b010);
    @(negedge clk);

    // start in the DONE cycle chains a second run.
    push(0, 16'hFFFF, 16'h0000);
    start_pulse(0, c0);
    feed(0, 16'hFFFF, 16'h0000, 16, 0, bc);
    wait_done(0, "done_ffff");
    chk("chain_agreat", {ag[0], bg[0], eq[0]}, 3'b100);
    push(0, 16'h0000, 16'h0001);
    start_pulse(0, c0);
    chk("chain_busy", {busy[0], done[0]}, 2'b10);
    feed(0, 16'h0000, 16'h0001, 16, 0, bc);
    wait_done(0, "done_chain");
    chk("chain_latency", cyc - c0, 17);
    chk("chain_bgreat", {ag[0], bg[0], eq[0]}, 3'b010);

    // Random operands on both orderings; some pairs differ in a single bit.
    for (int r = 0; r < 1000; r++) begin
      int sel;
      sel = r % 2;
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      push(sel, ra, rb);
      start_pulse(sel, c0);
      feed(sel, ra, rb, 16, 0, bc);
      wait_done(sel, "done_rand");
    end
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
